md_unit: RTL and testbench



---
 rtl/md_unit_pkg.sv | 44 ++++
 rtl/md_unit_arith.sv | 74 +++++++
 rtl/md_unit.sv | 118 +++++++++++
 tb/tb_md_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_pkg
// Shared definitions for the multiply/divide sequencer:
//   - md_op_e    : E-stage MD operation encodings (3 bits)
//   - md_state_e : sequencer state encodings
//   - default busy-cycle counts for multiply and divide
//   - CNT_W      : width of the busy down-counter
// -----------------------------------------------------------------------------
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // The busy counter is 4 bits wide, so cycle counts must lie in 1..15.
    localparam int CNT_W = 4;

    // True for the four operations that start a busy period.
    function automatic logic is_arith_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the two divide operations.
    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// -----------------------------------------------------------------------------
// md_arith
// Purely combinational multiply/divide datapath.
// Ports:
//   op_i        : MD operation (only MULT/MULTU/DIV/DIVU produce a result)
//   a_i, b_i    : 32-bit operands (rs, rt)
//   hi_o, lo_o  : product {hi,lo}, or remainder (hi) / quotient (lo)
//   div_zero_o  : divide operation with b_i == 0
// -----------------------------------------------------------------------------
module md_arith
    import md_unit_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_zero_o
);

    logic [63:0] a_sx, b_sx, a_zx, b_zx;
    logic [63:0] prod_s, prod_u;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, b_div;
    logic [31:0] qu_mag, ru_mag;
    logic [31:0] q_s, r_s;
    logic [31:0] q_u, r_u;

    // Signed product: sign-extend to 64 bits; the low 64 bits of the
    // unsigned product of two's-complement extensions are the signed product.
    assign a_sx   = {{32{a_i[31]}}, a_i};
    assign b_sx   = {{32{b_i[31]}}, b_i};
    assign a_zx   = {32'd0, a_i};
    assign b_zx   = {32'd0, b_i};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Substitute a divisor of 1 on divide-by-zero so the divider never
    // sees a zero; the sequencer discards the result in that case.
    assign div_zero_o = is_div_op(op_i) && (b_i == 32'd0);
    assign b_safe     = (b_i == 32'd0) ? 32'd1 : b_i;

    // Signed divide via magnitudes: quotient negated when signs differ,
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
    // magnitude 0x80000000 with no negation, i.e. LO=0x80000000, HI=0.
    assign a_neg  = a_i[31];
    assign b_neg  = b_safe[31];
    assign a_mag  = a_neg ? (32'd0 - a_i) : a_i;
    assign b_mag  = b_neg ? (32'd0 - b_safe) : b_safe;

    // One shared unsigned divider serves both flavours.
    assign b_div  = (op_i == MD_DIV) ? b_mag : b_safe;
    assign qu_mag = ((op_i == MD_DIV) ? a_mag : a_i) / b_div;
    assign ru_mag = ((op_i == MD_DIV) ? a_mag : a_i) % b_div;

    assign q_s = (a_neg ^ b_neg) ? (32'd0 - qu_mag) : qu_mag;
    assign r_s = a_neg ? (32'd0 - ru_mag) : ru_mag;
    assign q_u = qu_mag;
    assign r_u = ru_mag;

    always_comb begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        case (op_i)
            MD_MULT:  begin hi_o = prod_s[63:32]; lo_o = prod_s[31:0]; end
            MD_MULTU: begin hi_o = prod_u[63:32]; lo_o = prod_u[31:0]; end
            MD_DIV:   begin hi_o = r_s;           lo_o = q_s;          end
            MD_DIVU:  begin hi_o = r_u;           lo_o = q_u;          end
            default:  begin hi_o = 32'd0;         lo_o = 32'd0;        end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// E-stage multiply/divide sequencer owning the architectural HI/LO registers.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   Start      : E-stage mult/multu/div/divu issue pulse
//   MDOpE      : MD operation (md_op_e encoding)
//   AE, BE     : forwarded rs / rt values
//   MDInstrD   : D-stage instruction touches HI/LO
//   HI, LO     : architectural HI/LO
//   Busy       : operation in flight
//   MDStall    : stall request to the hazard unit
// A started operation holds Busy for exactly N cycles after the Start cycle;
// the result lands in HI/LO on the edge that drops Busy.
// -----------------------------------------------------------------------------
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOpE,
    input  logic [31:0] AE,
    input  logic [31:0] BE,
    input  logic        MDInstrD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        MDStall
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    md_op_e           op;
    logic [31:0]      ar_hi, ar_lo;
    logic             ar_div_zero;
    logic             start_arith;

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      pend_hi_q, pend_lo_q;
    logic             pend_dz_q;
    logic             busy_q;

    assign op          = md_op_e'(MDOpE);
    assign start_arith = Start && is_arith_op(op);

    md_arith u_arith (
        .op_i       (op),
        .a_i        (AE),
        .b_i        (BE),
        .hi_o       (ar_hi),
        .lo_o       (ar_lo),
        .div_zero_o (ar_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_arith) begin
                        // Result is captured at issue; the countdown only
                        // models the architectural latency.
                        pend_hi_q <= ar_hi;
                        pend_lo_q <= ar_lo;
                        pend_dz_q <= ar_div_zero;
                        cnt_q     <= is_div_op(op) ? DIV_LD : MULT_LD;
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                    end else if (op == MD_MTHI) begin
                        hi_q <= AE;
                    end else if (op == MD_MTLO) begin
                        lo_q <= AE;
                    end
                end
                ST_RUN: begin
                    // Any command arriving here is dropped, so a stray
                    // mthi/mtlo on the commit edge loses to the commit.
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        if (!pend_dz_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign Busy = busy_q;

    // Start is included because Busy only rises after the issue edge.
    assign MDStall = MDInstrD & (Start | busy_q);

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit
// Directed bench for md_unit with hand-computed expected HI/LO values.
// -----------------------------------------------------------------------------
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOpE;
    logic [31:0] AE, BE;
    logic        MDInstrD;
    logic [31:0] HI, LO;
    logic        Busy, MDStall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .MDOpE    (MDOpE),
        .AE       (AE),
        .BE       (BE),
        .MDInstrD (MDInstrD),
        .HI       (HI),
        .LO       (LO),
        .Busy     (Busy),
        .MDStall  (MDStall)
    );

    // Issuing while busy is illegal; the bench must never do it.
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(Start && Busy)) else begin
                bad++;
                $error("FAIL issue_while_busy obs=1 exp=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Return shortly after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue an arithmetic op and walk through its whole busy period.
    task automatic run_md(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic mdi,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0, lo0;
        hi0 = HI;
        lo0 = LO;
        Start = 1'b1; MDOpE = op; AE = a; BE = b; MDInstrD = mdi;
        #1;
        chk({name, "_start_busy"},  {31'd0, Busy},    32'd0);
        chk({name, "_start_stall"}, {31'd0, MDStall}, {31'd0, mdi});
        step();
        Start = 1'b0; MDOpE = 3'd0; AE = 32'd0; BE = 32'd0;
        #1;
        for (int i = 1; i <= n; i++) begin
            chk($sformatf("%s_busy_c%0d", name, i),  {31'd0, Busy},    32'd1);
            chk($sformatf("%s_stall_c%0d", name, i), {31'd0, MDStall}, {31'd0, mdi});
            // HI/LO must not move before the commit.
            if (i == n) begin
                chk({name, "_hi_hold"}, HI, hi0);
                chk({name, "_lo_hold"}, LO, lo0);
            end
            step();
            #1;
        end
        chk({name, "_busy_fall"},  {31'd0, Busy},    32'd0);
        chk({name, "_stall_fall"}, {31'd0, MDStall}, 32'd0);
        chk({name, "_hi"}, HI, exp_hi);
        chk({name, "_lo"}, LO, exp_lo);
        $display("txn %s op=%0d busy=%0d HI=%h LO=%h", name, op, n, HI, LO);
        MDInstrD = 1'b0;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        MDOpE = op; AE = v; Start = 1'b0;
        step();
        MDOpE = 3'd0; AE = 32'd0;
        #1;
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDOpE = 3'd0; AE = 32'd0; BE = 32'd0; MDInstrD = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_hi",    HI, 32'd0);
        chk("rst_lo",    LO, 32'd0);
        chk("rst_busy",  {31'd0, Busy},    32'd0);
        chk("rst_stall", {31'd0, MDStall}, 32'd0);
        $display("txn reset HI=%h LO=%h Busy=%0d", HI, LO, Busy);

        // Multiply, signed and unsigned
        run_md("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA);

        // Divide: truncation toward zero, remainder follows dividend
        run_md("div_m7_2",  3'd3, 32'hFFFF_FFF9, 32'd2,         10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_7_m2",  3'd3, 32'd7,         32'hFFFF_FFFE, 10, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md("divu_7_2",  3'd4, 32'd7,         32'd2,         10, 1'b0, 32'd1,         32'd3);
        run_md("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b1, 32'd0,         32'h8000_0000);

        // Divide by zero leaves preloaded HI/LO intact
        mt(3'd5, 32'h0000_1234);
        chk("mthi_pre", HI, 32'h0000_1234);
        mt(3'd6, 32'h0000_5678);
        chk("mtlo_pre", LO, 32'h0000_5678);
        run_md("div_by0", 3'd3, 32'd9, 32'd0, 10, 1'b1, 32'h0000_1234, 32'h0000_5678);
        run_md("divu_by0", 3'd4, 32'd9, 32'd0, 10, 1'b0, 32'h0000_1234, 32'h0000_5678);

        // mthi in IDLE: one edge, no busy period, LO untouched
        mt(3'd5, 32'hDEAD_BEEF);
        chk("mthi_hi",   HI, 32'hDEAD_BEEF);
        chk("mthi_lo",   LO, 32'h0000_5678);
        chk("mthi_busy", {31'd0, Busy}, 32'd0);
        $display("txn mthi HI=%h LO=%h Busy=%0d", HI, LO, Busy);

        // Reserved op with no Start does nothing
        mt(3'd7, 32'h1111_1111);
        chk("rsvd_hi",   HI, 32'hDEAD_BEEF);
        chk("rsvd_lo",   LO, 32'h0000_5678);
        chk("rsvd_busy", {31'd0, Busy}, 32'd0);

        // Stall low when MDInstrD is low even during Start
        Start = 1'b1; MDOpE = 3'd1; AE = 32'd6; BE = 32'd7; MDInstrD = 1'b0;
        #1;
        chk("rstmid_start_stall", {31'd0, MDStall}, 32'd0);
        step();
        Start = 1'b0; MDOpE = 3'd0;
        #1;
        chk("rstmid_c1_busy", {31'd0, Busy}, 32'd1);
        step();
        #1;
        chk("rstmid_c2_busy", {31'd0, Busy}, 32'd1);
        step();
        // Reset asserted during busy cycle 3
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, Busy}, 32'd0);
        chk("rstmid_hi",   HI, 32'd0);
        chk("rstmid_lo",   LO, 32'd0);
        for (int i = 0; i < 6; i++) step();
        #1;
        chk("rstmid_late_hi",   HI, 32'd0);
        chk("rstmid_late_lo",   LO, 32'd0);
        chk("rstmid_late_busy", {31'd0, Busy}, 32'd0);
        $display("txn reset_mid_op HI=%h LO=%h Busy=%0d", HI, LO, Busy);

        // Result still correct after an aborted op
        run_md("mult_after", 3'd1, 32'd6, 32'd7, 5, 1'b1, 32'd0, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
